// File: rtl/arb_fsm_param.sv
// N-agent bus arbiter FSM with registered one-hot grant and encoded owner id.
// Define ARB_HOLD_LIMIT_EN to enable the MAX_HOLD grant tenure limit.
module arb_fsm_param #(
  parameter int  NUM_REQ  = 4,
  parameter int  RR_MODE  = 1,
  parameter int  MAX_HOLD = 16,
  localparam int IDW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               hold_expired
);

  if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1) begin : g_bad_param
    $error("arb_fsm_param: illegal parameter value");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     last_q, last_d;

  logic [NUM_REQ-1:0]   cand;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDW-1:0]       win;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           excl_q, excl_d;
  logic           hexp_q, hexp_d;
  logic [NUM_REQ-1:0] last_oh;
`endif

  // Candidate set: an owner that just timed out yields to any other requester.
  always_comb begin
    cand = req;
`ifdef ARB_HOLD_LIMIT_EN
    last_oh = NUM_REQ'(1) << last_q;
    if (excl_q && |(req & ~last_oh)) begin
      cand = req & ~last_oh;
    end
`endif
  end

  always_comb begin
    int off;
    int tmp;
    off = 0;
    tmp = 0;
    dbl = {cand, cand};
    rot = cand;
    if (RR_MODE != 0) begin
      dbl = {cand, cand} >> (int'(last_q) + 1);
      rot = dbl[NUM_REQ-1:0];
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    if (RR_MODE != 0) begin
      tmp = int'(last_q) + 1 + off;
      if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
    end else begin
      tmp = off;
    end
    win = IDW'(tmp);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
    excl_d      = excl_q;
    hexp_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = NUM_REQ'(1) << win;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win;
          last_d      = win;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d  = HCW'(1);
          excl_d      = 1'b0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d  = '0;
        end else if (hold_cnt_q == HCW'(MAX_HOLD)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          hold_cnt_d  = '0;
          excl_d      = 1'b1;
          hexp_d      = 1'b1;
        end else begin
          hold_cnt_d  = hold_cnt_q + HCW'(1);
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
      excl_q      <= 1'b0;
      hexp_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
      excl_q      <= excl_d;
      hexp_q      <= hexp_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
`ifdef ARB_HOLD_LIMIT_EN
  assign hold_expired = hexp_q;
`else
  assign hold_expired = 1'b0;
`endif

endmodule

// File: tb/tb_arb_fsm_param.sv
// Scoreboard bench for arb_fsm_param: round-robin and fixed-priority
// instances share one request bus and are checked against a queue model.
module tb_arb_fsm_param;

  localparam int N  = 4;
  localparam int MH = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;

  logic [N-1:0] rr_gnt, fx_gnt;
  logic         rr_vld, fx_vld;
  logic [1:0]   rr_id, fx_id;
  logic         rr_hexp, fx_hexp;

  int n_chk  = 0;
  int n_pass = 0;

  arb_fsm_param #(.NUM_REQ(N), .RR_MODE(1), .MAX_HOLD(MH)) u_rr (
    .clock(clk), .reset(reset), .req(req),
    .gnt(rr_gnt), .gnt_valid(rr_vld), .gnt_id(rr_id),
    .hold_expired(rr_hexp)
  );

  arb_fsm_param #(.NUM_REQ(N), .RR_MODE(0), .MAX_HOLD(MH)) u_fx (
    .clock(clk), .reset(reset), .req(req),
    .gnt(fx_gnt), .gnt_valid(fx_vld), .gnt_id(fx_id),
    .hold_expired(fx_hexp)
  );

  always #5 clk = ~clk;

  // Reference model, index 0 = round-robin, 1 = fixed priority.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];
  bit m_excl[2];
  bit m_hexp[2];

  logic [15:0] exp_q[$];

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
  endtask

  function automatic int pick(int d, logic [N-1:0] r);
    logic [N-1:0] c;
    c = r;
    if (m_excl[d] && (r & ~(4'(1) << m_last[d])) != 0)
      c = r & ~(4'(1) << m_last[d]);
    if (d == 0) begin
      for (int k = 1; k <= N; k++)
        if (c[(m_last[d] + k) % N]) return (m_last[d] + k) % N;
    end else begin
      for (int k = 0; k < N; k++)
        if (c[k]) return k;
    end
    return -1;
  endfunction

  task automatic step(int d, logic [N-1:0] r, bit rst);
    int w;
    m_hexp[d] = 0;
    if (rst) begin
      m_owner[d] = -1; m_last[d] = N - 1;
      m_cnt[d] = 0; m_excl[d] = 0;
    end else if (m_owner[d] < 0) begin
      if (r != 0) begin
        w = pick(d, r);
        m_owner[d] = w; m_last[d] = w;
        m_cnt[d] = 1; m_excl[d] = 0;
      end
    end else if (!r[m_owner[d]]) begin
      m_owner[d] = -1;
`ifdef ARB_HOLD_LIMIT_EN
    end else if (m_cnt[d] == MH) begin
      m_owner[d] = -1; m_hexp[d] = 1; m_excl[d] = 1;
`endif
    end else begin
      m_cnt[d]++;
    end
  endtask

  function automatic logic [7:0] expv(int d);
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner[d] >= 0) ? 4'(1) << m_owner[d] : 4'd0;
    id = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
    return {g, m_owner[d] >= 0, id, m_hexp[d]};
  endfunction

  // One clock of stimulus: drive, predict, wait for the edge to pass.
  task automatic drive(logic [N-1:0] r, bit rst = 0);
    req = r;
    reset = rst;
    step(0, r, rst);
    step(1, r, rst);
    exp_q.push_back({expv(0), expv(1)});
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rr_out", {rr_gnt, rr_vld, rr_id, rr_hexp}, e[15:8]);
        chk("fx_out", {fx_gnt, fx_vld, fx_id, fx_hexp}, e[7:0]);
      end
    end
  end

  initial begin : stim
    logic [N-1:0] r;
    int k;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = N - 1;
      m_cnt[d] = 0; m_excl[d] = 0; m_hexp[d] = 0;
    end

    // Reset with all requests active, then first grant to agent 0.
    drive(4'b1111, 1);
    drive(4'b1111, 1);
    chk("rst_gnt", {rr_gnt, rr_vld, rr_id, 1'b0}, 8'b0);
    drive(4'b1111);
    chk("first_gnt", {rr_gnt, fx_gnt}, 8'b0001_0001);

    // Fixed priority: 1010 -> agent 1, release, then agent 3.
    drive(4'b0000, 1);
    drive(4'b1010);
    chk("fx_1010", {fx_gnt, 2'b0, fx_id}, {4'b0010, 2'b0, 2'd1});
    drive(4'b1000);
    chk("fx_rel", {fx_gnt, 4'b0}, 8'b0);
    drive(4'b1000);
    chk("fx_3", {fx_gnt, 2'b0, fx_id}, {4'b1000, 2'b0, 2'd3});

    // Round-robin rotation 0,1,2,3,0.
    drive(4'b0000, 1);
    for (int g = 0; g < 5; g++) begin
      k = g % N;
      drive(4'b1111);
      chk("rr_order", {rr_gnt, 2'b0, rr_id}, {4'(1) << k, 2'b0, 2'(k)});
      drive(4'b1111);
      drive(4'b1111 & ~(4'(1) << k));
      chk("rr_gap", {rr_gnt, 4'b0}, 8'b0);
    end

    // Reset mid-grant restores the pointer.
    drive(4'b0000, 1);
    drive(4'b0100);
    drive(4'b0100);
    chk("rr_own2", {rr_gnt, 4'b0}, {4'b0100, 4'b0});
    drive(4'b1111, 1);
    chk("mid_rst", {rr_gnt, 4'b0}, 8'b0);
    drive(4'b1111);
    chk("ptr_rst", {rr_gnt, 4'b0}, {4'b0001, 4'b0});

    // Other requests are ignored during a grant; idle stays idle.
    drive(4'b0000, 1);
    drive(4'b0010);
    foreach (r[i]) begin
      drive(4'b0010 | 4'((i * 5 + 1) & 4'b1001));
      chk("fx_hold", {fx_gnt, 4'b0}, {4'b0010, 4'b0});
    end
    drive(4'b0000);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000);
      chk("idle_vld", {7'b0, fx_vld}, 8'b0);
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Tenure limit: forced release and hand-over to the other requester.
    drive(4'b0000, 1);
    for (int i = 0; i < MH; i++) begin
      drive(4'b0011);
      chk("hl_own0", {fx_gnt, 4'b0}, {4'b0001, 4'b0});
    end
    drive(4'b0011);
    chk("hl_exp", {fx_gnt, 3'b0, fx_hexp}, 8'b0000_0001);
    drive(4'b0011);
    chk("hl_own1", {fx_gnt, 4'b0}, {4'b0010, 4'b0});
    drive(4'b0000, 1);
    for (int i = 0; i <= MH; i++) drive(4'b0001);
    drive(4'b0001);
    chk("hl_regrant", {fx_gnt, 4'b0}, {4'b0001, 4'b0});
`endif

    // Randomised traffic with sticky requests and occasional reset.
    r = 4'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      drive(r, $urandom_range(63) == 0);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
